// File: rtl/fetch_decode_n_pkg.sv
// Front-end shared definitions: instruction layout, opcodes and decode classes.
// Latency: none (package of constants and pure functions).
// Backpressure: not applicable.
package fe_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 8;

    // Field bit positions inside one 16-bit instruction
    localparam int OP_LSB  = 12;
    localparam int RT_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_AND  = 4'd4,
        OP_LI   = 4'd5,
        OP_LUI  = 4'd6,
        OP_RSV7 = 4'd7,
        OP_BR   = 4'd8,
        OP_BZ   = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11
    } opcode_e;

    function automatic logic uses_ra(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LD, OP_ST, OP_AND,
            OP_BR, OP_BZ, OP_BEQ, OP_BNE: uses_ra = 1'b1;
            default:                      uses_ra = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rb(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_BEQ, OP_BNE: uses_rb = 1'b1;
            default:                                uses_rb = 1'b0;
        endcase
    endfunction

    function automatic logic is_fxu(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_LI, OP_LUI: is_fxu = 1'b1;
            default:                               is_fxu = 1'b0;
        endcase
    endfunction

    function automatic logic is_ldst(input logic [3:0] op);
        is_ldst = (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        is_branch = (op >= 4'd8) && (op <= 4'd11);
    endfunction

endpackage

// File: rtl/group_dep_resolve.sv
// Intra-group RAW resolution: each source takes the tag of the youngest older valid producer.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module group_dep_resolve
    import fe_pkg::*;
#(
    parameter int FETCH_W   = 4,
    parameter int ROB_IDX_W = 4
) (
    input  logic [REG_W*FETCH_W-1:0]     i_rt,
    input  logic [REG_W*FETCH_W-1:0]     i_ra,
    input  logic [REG_W*FETCH_W-1:0]     i_rb,
    input  logic [FETCH_W-1:0]           i_uses_ra,
    input  logic [FETCH_W-1:0]           i_uses_rb,
    input  logic [FETCH_W-1:0]           i_valid,
    input  logic [ROB_IDX_W-1:0]         i_tail,
    output logic [FETCH_W-1:0]           o_a_dep,
    output logic [FETCH_W-1:0]           o_b_dep,
    output logic [ROB_IDX_W*FETCH_W-1:0] o_a_owner,
    output logic [ROB_IDX_W*FETCH_W-1:0] o_b_owner
);

    // Scan older slots in ascending order so the youngest matching producer wins
    always_comb begin
        o_a_dep   = '0;
        o_b_dep   = '0;
        o_a_owner = '0;
        o_b_owner = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            o_a_owner[ROB_IDX_W*i +: ROB_IDX_W] = i_tail + ROB_IDX_W'(i);
            o_b_owner[ROB_IDX_W*i +: ROB_IDX_W] = i_tail + ROB_IDX_W'(i);
            for (int j = 0; j < i; j++) begin
                if (i_uses_ra[i] && i_valid[j] &&
                    (i_rt[REG_W*j +: REG_W] == i_ra[REG_W*i +: REG_W])) begin
                    o_a_dep[i] = 1'b1;
                    o_a_owner[ROB_IDX_W*i +: ROB_IDX_W] = i_tail + ROB_IDX_W'(j);
                end
                if (i_uses_rb[i] && i_valid[j] &&
                    (i_rt[REG_W*j +: REG_W] == i_rb[REG_W*i +: REG_W])) begin
                    o_b_dep[i] = 1'b1;
                    o_b_owner[ROB_IDX_W*i +: ROB_IDX_W] = i_tail + ROB_IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fetch_decode_n.sv
// FETCH_W-wide fetch + decode front end with output register, one-entry skid and redirect epoch.
// Latency: request at t, icache response at t+1, registered dec_valid at t+2.
// Backpressure: dec_ready low holds the group; fetch stalls once two groups are held or in flight.
module fetch_decode_n
    import fe_pkg::*;
#(
    parameter int          FETCH_W        = 4,
    parameter int          PC_W           = 16,
    parameter int          ROB_IDX_W      = 4,
    parameter int unsigned RESET_PC       = 0,
    parameter bit          STOP_AT_BRANCH = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic                         icache_req_valid,
    output logic [PC_W-1:0]              icache_req_pc,
    input  logic                         icache_resp_valid,
    input  logic [INSTR_W*FETCH_W-1:0]   icache_resp_data,
    input  logic [ROB_IDX_W-1:0]         rob_tail_idx,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [FETCH_W-1:0]           dec_slot_valid,
    output logic [PC_W-1:0]              dec_pc,
    output logic [REG_W*FETCH_W-1:0]     dec_opcode,
    output logic [REG_W*FETCH_W-1:0]     dec_rt,
    output logic [REG_W*FETCH_W-1:0]     dec_ra,
    output logic [REG_W*FETCH_W-1:0]     dec_rb,
    output logic [IMM_W*FETCH_W-1:0]     dec_imm,
    output logic [FETCH_W-1:0]           dec_uses_ra,
    output logic [FETCH_W-1:0]           dec_uses_rb,
    output logic [FETCH_W-1:0]           dec_is_fxu,
    output logic [FETCH_W-1:0]           dec_is_ldst,
    output logic [FETCH_W-1:0]           dec_is_branch,
    output logic [FETCH_W-1:0]           dec_a_dep,
    output logic [FETCH_W-1:0]           dec_b_dep,
    output logic [ROB_IDX_W*FETCH_W-1:0] dec_a_owner,
    output logic [ROB_IDX_W*FETCH_W-1:0] dec_b_owner
);

    localparam int              GRP_W     = INSTR_W * FETCH_W;
    localparam logic [PC_W-1:0] GRP_BYTES = PC_W'(2 * FETCH_W);

    logic              r_epoch, r_inflight, r_inflight_epoch;
    logic [PC_W-1:0]   r_fetch_pc, r_inflight_pc;
    logic              r_out_vld, r_skid_vld;
    logic [PC_W-1:0]   r_out_pc, r_skid_pc;
    logic [GRP_W-1:0]  r_out_dat, r_skid_dat;

    logic              w_drain, w_room, w_resp_ok;
    logic [1:0]        w_occ;

    // Occupancy counts held groups plus the response due this cycle; a drain frees one slot
    always_comb begin
        w_drain          = r_out_vld & dec_ready;
        w_occ            = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_inflight);
        w_room           = (w_occ <= (2'(w_drain) + 2'd1));
        icache_req_valid = ~rst & (redirect_valid | w_room);
        icache_req_pc    = redirect_valid ? redirect_pc : r_fetch_pc;
        w_resp_ok        = icache_resp_valid & r_inflight &
                           (r_inflight_epoch == r_epoch) & ~redirect_valid;
    end

    // Fetch PC, epoch and in-flight request tracking; a redirect request carries the new epoch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc       <= PC_W'(RESET_PC);
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_inflight_pc    <= '0;
        end else begin
            r_inflight       <= icache_req_valid;
            r_inflight_pc    <= icache_req_pc;
            r_inflight_epoch <= redirect_valid ? ~r_epoch : r_epoch;
            if (redirect_valid)
                r_epoch <= ~r_epoch;
            if (icache_req_valid)
                r_fetch_pc <= icache_req_pc + GRP_BYTES;
        end
    end

    // Output register and skid: skid refills first so group order is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_pc   <= '0;
            r_out_dat  <= '0;
            r_skid_vld <= 1'b0;
            r_skid_pc  <= '0;
            r_skid_dat <= '0;
        end else if (redirect_valid) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_out_vld || w_drain) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_pc   <= r_skid_pc;
                r_out_dat  <= r_skid_dat;
                r_skid_vld <= w_resp_ok;
                r_skid_pc  <= r_inflight_pc;
                r_skid_dat <= icache_resp_data;
            end else begin
                r_out_vld <= w_resp_ok;
                if (w_resp_ok) begin
                    r_out_pc  <= r_inflight_pc;
                    r_out_dat <= icache_resp_data;
                end
            end
        end else if (w_resp_ok) begin
            r_skid_vld <= 1'b1;
            r_skid_pc  <= r_inflight_pc;
            r_skid_dat <= icache_resp_data;
        end
    end

    logic [REG_W*FETCH_W-1:0] w_op, w_rt, w_ra, w_rb;
    logic [IMM_W*FETCH_W-1:0] w_imm;
    logic [FETCH_W-1:0]       w_uses_ra, w_uses_rb, w_is_fxu, w_is_ldst, w_is_branch, w_slot_vld;
    logic [FETCH_W-1:0]       w_a_dep, w_b_dep;
    logic [ROB_IDX_W*FETCH_W-1:0] w_a_owner, w_b_owner;

    // Field split, class decode and the slot mask that cuts after the first branch
    always_comb begin : slot_decode
        logic seen_br;
        seen_br     = 1'b0;
        w_op        = '0;
        w_rt        = '0;
        w_ra        = '0;
        w_rb        = '0;
        w_imm       = '0;
        w_uses_ra   = '0;
        w_uses_rb   = '0;
        w_is_fxu    = '0;
        w_is_ldst   = '0;
        w_is_branch = '0;
        w_slot_vld  = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_op[REG_W*i +: REG_W]  = r_out_dat[INSTR_W*i + OP_LSB  +: REG_W];
            w_rt[REG_W*i +: REG_W]  = r_out_dat[INSTR_W*i + RT_LSB  +: REG_W];
            w_ra[REG_W*i +: REG_W]  = r_out_dat[INSTR_W*i + RA_LSB  +: REG_W];
            w_rb[REG_W*i +: REG_W]  = r_out_dat[INSTR_W*i + RB_LSB  +: REG_W];
            w_imm[IMM_W*i +: IMM_W] = r_out_dat[INSTR_W*i + IMM_LSB +: IMM_W];
            w_uses_ra[i]   = uses_ra(w_op[REG_W*i +: REG_W]);
            w_uses_rb[i]   = uses_rb(w_op[REG_W*i +: REG_W]);
            w_is_fxu[i]    = is_fxu(w_op[REG_W*i +: REG_W]);
            w_is_ldst[i]   = is_ldst(w_op[REG_W*i +: REG_W]);
            w_is_branch[i] = is_branch(w_op[REG_W*i +: REG_W]);
            w_slot_vld[i]  = !(STOP_AT_BRANCH && seen_br);
            seen_br        = seen_br | w_is_branch[i];
        end
    end

    group_dep_resolve #(
        .FETCH_W   (FETCH_W),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_dep (
        .i_rt      (w_rt),
        .i_ra      (w_ra),
        .i_rb      (w_rb),
        .i_uses_ra (w_uses_ra),
        .i_uses_rb (w_uses_rb),
        .i_valid   (w_slot_vld),
        .i_tail    (rob_tail_idx),
        .o_a_dep   (w_a_dep),
        .o_b_dep   (w_b_dep),
        .o_a_owner (w_a_owner),
        .o_b_owner (w_b_owner)
    );

    // Present decode only while a group is held; fields read zero otherwise
    always_comb begin
        dec_valid      = r_out_vld;
        dec_pc         = r_out_vld ? r_out_pc    : '0;
        dec_slot_valid = r_out_vld ? w_slot_vld  : '0;
        dec_opcode     = r_out_vld ? w_op        : '0;
        dec_rt         = r_out_vld ? w_rt        : '0;
        dec_ra         = r_out_vld ? w_ra        : '0;
        dec_rb         = r_out_vld ? w_rb        : '0;
        dec_imm        = r_out_vld ? w_imm       : '0;
        dec_uses_ra    = r_out_vld ? w_uses_ra   : '0;
        dec_uses_rb    = r_out_vld ? w_uses_rb   : '0;
        dec_is_fxu     = r_out_vld ? w_is_fxu    : '0;
        dec_is_ldst    = r_out_vld ? w_is_ldst   : '0;
        dec_is_branch  = r_out_vld ? w_is_branch : '0;
        dec_a_dep      = r_out_vld ? w_a_dep     : '0;
        dec_b_dep      = r_out_vld ? w_b_dep     : '0;
        dec_a_owner    = r_out_vld ? w_a_owner   : '0;
        dec_b_owner    = r_out_vld ? w_b_owner   : '0;
    end

endmodule

// File: tb/tb_fetch_decode_n.sv
// Directed bench for fetch_decode_n with a one-cycle icache model backed by a small word memory.
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
module tb_fetch_decode_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        icache_req_valid;
    logic [15:0] icache_req_pc;
    logic        icache_resp_valid;
    logic [63:0] icache_resp_data;
    logic [3:0]  rob_tail_idx;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_slot_valid;
    logic [15:0] dec_pc;
    logic [15:0] dec_opcode, dec_rt, dec_ra, dec_rb;
    logic [31:0] dec_imm;
    logic [3:0]  dec_uses_ra, dec_uses_rb, dec_is_fxu, dec_is_ldst, dec_is_branch;
    logic [3:0]  dec_a_dep, dec_b_dep;
    logic [15:0] dec_a_owner, dec_b_owner;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [0:255];
    logic [15:0] acc_q [$];

    always #5 clk = ~clk;

    fetch_decode_n #(
        .FETCH_W(4), .PC_W(16), .ROB_IDX_W(4), .RESET_PC(0), .STOP_AT_BRANCH(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_req_valid(icache_req_valid), .icache_req_pc(icache_req_pc),
        .icache_resp_valid(icache_resp_valid), .icache_resp_data(icache_resp_data),
        .rob_tail_idx(rob_tail_idx),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_slot_valid(dec_slot_valid), .dec_pc(dec_pc),
        .dec_opcode(dec_opcode), .dec_rt(dec_rt), .dec_ra(dec_ra), .dec_rb(dec_rb),
        .dec_imm(dec_imm),
        .dec_uses_ra(dec_uses_ra), .dec_uses_rb(dec_uses_rb), .dec_is_fxu(dec_is_fxu),
        .dec_is_ldst(dec_is_ldst), .dec_is_branch(dec_is_branch),
        .dec_a_dep(dec_a_dep), .dec_b_dep(dec_b_dep),
        .dec_a_owner(dec_a_owner), .dec_b_owner(dec_b_owner)
    );

    function automatic logic [63:0] build_grp(input logic [15:0] pc);
        logic [63:0] d;
        logic [7:0]  idx;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            idx = pc[8:1] + 8'(i);
            d[16*i +: 16] = mem[idx];
        end
        return d;
    endfunction

    // icache: answers every request exactly one cycle later
    always @(posedge clk) begin
        if (rst) begin
            icache_resp_valid <= 1'b0;
            icache_resp_data  <= '0;
        end else begin
            icache_resp_valid <= icache_req_valid;
            icache_resp_data  <= build_grp(icache_req_pc);
        end
    end

    // record every group accepted by the instruction buffer
    always @(posedge clk) begin
        if (!rst && dec_valid && dec_ready)
            acc_q.push_back(dec_pc);
    end

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        dec_ready = 1'b1; rob_tail_idx = 4'd14;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (icache_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: req_valid=%b dec_valid=%b, want 0 0", icache_req_valid, dec_valid);
        end
        n_tests++;
        if (dec_slot_valid !== 4'h0 || dec_a_owner !== 16'h0 || dec_pc !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_fields: mask=%h a_owner=%h pc=%h, want 0", dec_slot_valid, dec_a_owner, dec_pc);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_pc = 16'(8 * c);
            n_tests++;
            if (icache_req_valid !== 1'b1 || icache_req_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL req_seq c%0d: valid=%b pc=%h, want 1 %h", c, icache_req_valid, icache_req_pc, exp_pc);
            end
            n_tests++;
            if (dec_valid !== (c == 2)) begin
                n_fail++;
                $display("FAIL first_valid c%0d: dec_valid=%b, want %b", c, dec_valid, (c == 2));
            end
        end
        n_tests++;
        if (dec_pc !== 16'h0000 || dec_slot_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL first_group: pc=%h mask=%b, want 0000 1111", dec_pc, dec_slot_valid);
        end
    endtask

    // still on the cycle where group pc 0 is presented with rob_tail 14
    task automatic test_deps();
        n_tests++;
        if (dec_a_owner !== 16'h1FEE || dec_a_dep !== 4'b0110) begin
            n_fail++;
            $display("FAIL deps_a: owner=%h dep=%b, want 1fee 0110", dec_a_owner, dec_a_dep);
        end
        n_tests++;
        if (dec_b_owner !== 16'h1EEE || dec_b_dep !== 4'b0110) begin
            n_fail++;
            $display("FAIL deps_b: owner=%h dep=%b, want 1eee 0110", dec_b_owner, dec_b_dep);
        end
        n_tests++;
        if (dec_opcode !== 16'h5000 || dec_rt !== 16'h2141 || dec_imm !== 32'h00411123) begin
            n_fail++;
            $display("FAIL fields: op=%h rt=%h imm=%h, want 5000 2141 00411123", dec_opcode, dec_rt, dec_imm);
        end
        n_tests++;
        if (dec_is_fxu !== 4'b1111 || dec_uses_rb !== 4'b0111 || dec_uses_ra !== 4'b0111 ||
            dec_is_ldst !== 4'b0000 || dec_is_branch !== 4'b0000) begin
            n_fail++;
            $display("FAIL classes: fxu=%b urb=%b ura=%b ldst=%b br=%b, want 1111 0111 0111 0000 0000",
                     dec_is_fxu, dec_uses_rb, dec_uses_ra, dec_is_ldst, dec_is_branch);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0008) begin
            n_fail++;
            $display("FAIL second_group: valid=%b pc=%h, want 1 0008", dec_valid, dec_pc);
        end
        dec_ready = 1'b0;
        acc_q.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== 16'h0008 || icache_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall c%0d: valid=%b pc=%h req=%b, want 1 0008 0", c, dec_valid, dec_pc, icache_req_valid);
            end
        end
        dec_ready = 1'b1;
        #1;
        n_tests++;
        if (icache_req_valid !== 1'b1 || icache_req_pc !== 16'h0018) begin
            n_fail++;
            $display("FAIL release_req: valid=%b pc=%h, want 1 0018", icache_req_valid, icache_req_pc);
        end
        repeat (4) @(negedge clk);
        #1;
        n_tests++;
        if (acc_q.size() != 4 || acc_q[0] !== 16'h0008 || acc_q[1] !== 16'h0010 || acc_q[2] !== 16'h0018) begin
            n_fail++;
            $display("FAIL release_order: n=%0d first=%h,%h,%h, want 4 0008,0010,0018", acc_q.size(),
                     (acc_q.size() > 0) ? acc_q[0] : 16'hxxxx, (acc_q.size() > 1) ? acc_q[1] : 16'hxxxx,
                     (acc_q.size() > 2) ? acc_q[2] : 16'hxxxx);
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        acc_q.delete();
        #1;
        n_tests++;
        if (icache_req_valid !== 1'b1 || icache_req_pc !== 16'h0040) begin
            n_fail++;
            $display("FAIL redirect_req: valid=%b pc=%h, want 1 0040", icache_req_valid, icache_req_pc);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (dec_valid !== 1'b0 || icache_req_pc !== 16'h0048) begin
            n_fail++;
            $display("FAIL redirect_flush: dec_valid=%b req_pc=%h, want 0 0048", dec_valid, icache_req_pc);
        end
        dec_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0040) begin
            n_fail++;
            $display("FAIL redirect_target: valid=%b pc=%h, want 1 0040", dec_valid, dec_pc);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (acc_q.size() != 1 || acc_q[0] !== 16'h0040 || dec_pc !== 16'h0048) begin
            n_fail++;
            $display("FAIL redirect_stale: n=%0d first=%h now=%h, want 1 0040 0048", acc_q.size(),
                     (acc_q.size() > 0) ? acc_q[0] : 16'hxxxx, dec_pc);
        end
    endtask

    task automatic test_branch();
        dec_ready = 1'b0;
        rob_tail_idx = 4'd2;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0080 || dec_slot_valid !== 4'b0011 || dec_is_branch !== 4'b0010) begin
            n_fail++;
            $display("FAIL branch_mask: valid=%b pc=%h mask=%b br=%b, want 1 0080 0011 0010",
                     dec_valid, dec_pc, dec_slot_valid, dec_is_branch);
        end
        n_tests++;
        if (dec_a_owner !== 16'h5332 || dec_a_dep !== 4'b0100 || dec_b_owner !== 16'h5432 || dec_b_dep !== 4'b0000) begin
            n_fail++;
            $display("FAIL branch_owner: a=%h/%b b=%h/%b, want 5332/0100 5432/0000",
                     dec_a_owner, dec_a_dep, dec_b_owner, dec_b_dep);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0080 || dec_opcode !== 16'h0090) begin
            n_fail++;
            $display("FAIL hold_stable: valid=%b pc=%h op=%h, want 1 0080 0090", dec_valid, dec_pc, dec_opcode);
        end
    endtask

    task automatic test_reset_mid();
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (dec_valid !== 1'b0 || icache_req_valid !== 1'b0 || dec_pc !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: dec_valid=%b req=%b pc=%h, want 0 0 0000", dec_valid, icache_req_valid, dec_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        dec_ready = 1'b1;
        rob_tail_idx = 4'd14;
        #1;
        n_tests++;
        if (icache_req_valid !== 1'b1 || icache_req_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL restart_req: valid=%b pc=%h, want 1 0000", icache_req_valid, icache_req_pc);
        end
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0000 || dec_a_owner !== 16'h1FEE) begin
            n_fail++;
            $display("FAIL restart_group: valid=%b pc=%h a_owner=%h, want 1 0000 1fee", dec_valid, dec_pc, dec_a_owner);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'h5000 | 16'(k);
        mem[0]  = 16'h0123;
        mem[1]  = 16'h0411;
        mem[2]  = 16'h0141;
        mem[3]  = 16'h5200;
        mem[64] = 16'h0123;
        mem[65] = 16'h9150;
        mem[66] = 16'h0710;
        mem[67] = 16'h0077;
        test_reset();
        test_stream();
        test_deps();
        test_back_to_back();
        test_redirect();
        test_branch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
